// File: rtl/fifo_push_ctrl.sv
// fifo_push_ctrl: write-side producer for the dual-clock FIFO (wclk domain).
// Upstream beats enter a 2-entry skid buffer over valid/ready. The buffer head
// is presented to the FIFO write port, and wfull stalls the pop. Once the last
// beat of a frame has been written, a one-cycle frame_done pulse is raised.
// frame_len carries the saturating beat count of that frame.
module fifo_push_ctrl #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 8
) (
   input  logic             wclk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             winc,
   output logic [WIDTH-1:0] wdata,
   input  logic             wfull,
   output logic             frame_done,
   output logic [LEN_W-1:0] frame_len,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DONE} state_t;

   typedef struct packed {
      logic             last;
      logic [WIDTH-1:0] data;
   } entry_t;

   state_t           state;
   entry_t [1:0]     skid;      // skid[0] is the head
   logic   [1:0]     count;
   logic   [LEN_W-1:0] fcnt;

   logic   acc;
   logic   pop;
   logic   wr_idx;
   entry_t new_ent;

   // All outputs toward the FIFO and upstream are decoded from registers only,
   // so wfull and in_valid never reach winc/wdata/in_ready combinationally.
   assign in_ready = (count != 2'd2) && ((state == IDLE) || (state == ACTIVE));
   assign winc     = (count != 2'd0);
   assign wdata    = winc ? skid[0].data : '0;
   assign busy     = (state != IDLE) || (count != 2'd0);

   assign acc     = in_valid && in_ready;
   assign pop     = winc && !wfull;
   assign new_ent = '{last: in_last, data: in_data};

   // The tail slot is 0 when empty, or when the only entry leaves this cycle.
   assign wr_idx = (count == 2'd1) && !pop;

   // Skid buffer storage and occupancy; a pop shifts the tail into the head.
   always_ff @(posedge wclk or negedge rst_n) begin
      if (!rst_n) begin
         skid  <= '0;
         count <= 2'd0;
      end else begin
         if (pop)
            skid[0] <= skid[1];
         if (acc)
            skid[wr_idx] <= new_ent;
         count <= count + 2'(acc) - 2'(pop);
      end
   end

   // Beat counter for the current frame, saturating at all-ones.
   always_ff @(posedge wclk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt <= '0;
      end else if (acc) begin
         if (state == IDLE)
            fcnt <= LEN_W'(1);
         else if (fcnt != '1)
            fcnt <= fcnt + LEN_W'(1);
      end
   end

   // Frame FSM with registered completion pulse and length.
   always_ff @(posedge wclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         frame_done <= 1'b0;
         frame_len  <= '0;
      end else begin
         case (state)
            IDLE: begin
               frame_done <= 1'b0;
               if (acc)
                  state <= in_last ? FLUSH : ACTIVE;
            end
            ACTIVE: begin
               frame_done <= 1'b0;
               if (acc && in_last)
                  state <= FLUSH;
            end
            FLUSH: begin
               // No accepts here, so fcnt already holds the final length.
               if (pop && skid[0].last) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
                  frame_len  <= fcnt;
               end
            end
            DONE: begin
               state      <= IDLE;
               frame_done <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               frame_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/fifo_push_ctrl.md
Name: fifo_push_ctrl

Overview:
Write-side producer for the dual-clock FIFO, in the wclk domain. Accepts framed data beats from clk1 logic over a valid/ready handshake and buffers them in a 2-entry skid buffer. Drives the FIFO write port (winc/wdata) and honours its wfull back-pressure. Reports frame completion and frame length once the last beat of a frame has been written into the FIFO.

Parameters:
WIDTH, 8, data beat width; matches the FIFO data width.
LEN_W, 8, width of the frame-length counter.

Ports:
wclk  input  1  write-domain clock.
rst_n  input  1  reset, asynchronous, active-low.
in_valid  input  1  upstream beat valid.
in_data  input  WIDTH  upstream beat data.
in_last  input  1  beat is the last of its frame; sampled with in_valid.
in_ready  output  1  block can accept a beat this cycle.
winc  output  1  FIFO write request.
wdata  output  WIDTH  FIFO write data.
wfull  input  1  FIFO full flag, wclk domain.
frame_done  output  1  one-cycle pulse: last beat of the frame is written to the FIFO.
frame_len  output  LEN_W  beats in the completed frame; valid while frame_done=1, held until the next frame_done.
busy  output  1  a frame is in progress or the buffer is non-empty.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, buffer count=0, buffer contents discarded, frame counter=0.
- Reset output values: in_ready=1, winc=0, wdata=0, frame_done=0, frame_len=0, busy=0.
- Reset mid-frame: partial frame discarded, no frame_done. The FIFO shares rst_n, so both ends clear together.
- Skid buffer: 2 entries {data, last}, FIFO-ordered, count 0..2.
- Accept: at a wclk edge where in_valid && in_ready, the beat is stored at the tail.
- Push: winc = (count != 0); wdata = head data.
  - wdata = 0 when count = 0.
  - winc and wdata are decoded from registers only; there is no combinational path from wfull or in_valid.
- Pop: at a wclk edge where winc && !wfull, the head is removed. The FIFO writes the same word at the same edge.
- Accept and pop in the same cycle: count is unchanged and order is preserved.
- Accept with count=0 and wfull=0: the beat reaches the FIFO on the next edge, one cycle after acceptance.
- in_ready = (count != 2) && (state == IDLE || state == ACTIVE). It is decoded from registers only.
- wfull held high: winc stays 1 and wdata stays stable; no beat is lost or duplicated. in_ready drops once count=2.
- States:
  - IDLE: no frame in progress. An accept with in_last=0 goes to ACTIVE. An accept with in_last=1 (single-beat frame) goes to FLUSH.
  - ACTIVE: accepts beats. An accept with in_last=1 goes to FLUSH.
  - FLUSH: in_ready=0; drains the buffer. A pop of the entry whose last flag is set goes to DONE.
  - DONE: exactly one cycle. frame_done=1, in_ready=0, then go to IDLE.
- Frame counter:
  - The first accepted beat of a frame (in IDLE) loads the counter to 1.
  - Each further accept increments it, saturating at 2^LEN_W-1.
  - frame_len is registered from the counter on entry to DONE.
- busy = (state != IDLE) || (count != 0).
- A new frame can be accepted on the cycle after DONE. Back-to-back frames therefore have a 2-cycle minimum gap on in_ready: FLUSH drain, then DONE.
- X on in_data or in_last when in_valid=0 must not affect state.

Test Plan:
- Reset check: hold rst_n=0 -> in_ready=1, winc=0, frame_done=0, frame_len=0, busy=0.
- Single-beat frame: in_valid=1, in_data=8'hA5, in_last=1, wfull=0 -> next cycle winc=1, wdata=A5. The FIFO holds A5. frame_done pulses 1 cycle with frame_len=1. in_ready returns to 1 in IDLE.
- Streaming frame of 5 beats 01..05, wfull=0, continuous valid -> FIFO receives 01..05 in order. frame_done pulses once with frame_len=5. No in_ready drop before in_last.
- Back-pressure: wfull=1 during beats 2-6 of a 6-beat frame 10..15 -> in_ready=0 after 2 buffered beats. winc held with wdata stable. Release wfull -> FIFO receives 10..15 exactly once. frame_len=6.
- Saturation with LEN_W=4: 20-beat frame -> frame_len=15; all 20 beats written to the FIFO.
- Reset mid-frame: assert rst_n=0 after 3 of 5 beats with wfull=1 -> outputs return to reset values, no frame_done. A new 2-beat frame after release gives frame_len=2.
